sirv_vga_timing_gen: RTL

//  Source end of the VGA pixel interface used by the text-overlay peripheral.
//  - Generates 640x480@60 raster timing (hsync, vsync, data enable) on vga_clk.
//  - Issues pixel_xpos/pixel_ypos requests PIX_LAT cycles ahead of the active pixel.
//  - Samples the returned pixel_data into a registered 12-bit RGB output,

---
 rtl/sirv_vga_timing_gen_if.sv | 25 ++
 rtl/sirv_vga_timing_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/sirv_vga_timing_gen_if.sv
// Pixel-source bundle of the VGA timing generator: look-ahead requests out,
// returned RGB444 in, plus the registered raster outputs to the DAC.
interface sirv_vga_timing_gen_if;
  logic [11:0] pixel_data;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        data_req;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [11:0] vga_rgb;
  logic        frame_start;

  modport master (
    input  pixel_data,
    output pixel_xpos, pixel_ypos, data_req,
    output vga_hs, vga_vs, vga_de, vga_rgb, frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos, pixel_ypos, data_req,
    input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start
  );
endinterface

// File: rtl/sirv_vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, look-ahead pixel requests
// and a registered RGB444 output aligned with vga_hs, vga_vs and vga_de.
module sirv_vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned PIX_LAT  = 1,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  sirv_vga_timing_gen_if.master vga
);

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC);
  localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_START   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END     = 11'(V_SYNC + V_BACK + V_DISP);
  // Requests lead the displayed pixel by PIX_LAT clocks.
  localparam logic [10:0] REQ_START = 11'(H_SYNC + H_BACK - PIX_LAT);
  localparam logic [10:0] REQ_END   = 11'(H_SYNC + H_BACK + H_DISP - PIX_LAT);

  if (PIX_LAT < 1 || PIX_LAT > H_BACK) begin : g_bad_pix_lat
    $error("PIX_LAT must lie within 1..H_BACK");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
      H_SYNC + H_BACK + H_DISP > H_TOTAL || V_SYNC + V_BACK + V_DISP > V_TOTAL) begin : g_bad_raster
    $error("raster parameters do not fit the 10-bit counters");
  end

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q;
  logic [11:0] rgb_q, rgb_d;
  logic        fs_q, fs_d;
  logic [10:0] h_ext, v_ext;
  logic        vact, de_raw, req;
  logic [10:0] xpos_full, ypos_full;

  assign h_ext = {1'b0, h_cnt_q};
  assign v_ext = {1'b0, v_cnt_q};

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    vact      = (v_ext >= V_START) && (v_ext < V_END);
    de_raw    = vact && (h_ext >= H_START) && (h_ext < H_END);
    req       = vact && (h_ext >= REQ_START) && (h_ext < REQ_END);
    xpos_full = req ? h_ext - REQ_START : '0;
    ypos_full = req ? v_ext - V_START : '0;
  end

  always_comb begin
    hs_d  = (h_cnt_q < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_cnt_q < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
    // Blanking data from the source is dropped here, never shown.
    rgb_d = de_raw ? vga.pixel_data : 12'h000;
    fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_raw;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign vga.data_req    = req;
  assign vga.pixel_xpos  = xpos_full[9:0];
  assign vga.pixel_ypos  = ypos_full[9:0];
  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.vga_de      = de_q;
  assign vga.vga_rgb     = rgb_q;
  assign vga.frame_start = fs_q;

endmodule
